// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Holds the FSM encoding, the control-bundle struct and the load-use hit rule.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LDUSE = 2'd1,
    FLUSH = 2'd2
  } hazard_state_t;

  localparam logic [4:0] XZR   = 5'd31;
  localparam int         CNT_W = 16;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_hold;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_HOLD  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctrl_t CTRL_FLUSH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_STALL = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  // X31 reads as zero, so a load targeting it never feeds a real dependency.
  function automatic logic load_use_hit(
    input logic       mem_read,
    input logic [4:0] target,
    input logic [4:0] rn,
    input logic [4:0] rm,
    input logic       use_rm
  );
    return mem_read && (target != XZR) &&
           ((target == rn) || (use_rm && (target == rm)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-register fields in, stage-control strobes and perf counters out.
// slave is the hazard sequencer; master is the pipeline datapath.
interface hazard_ctrl_if;
  logic        MemRead_EX;
  logic [4:0]  targetReg_EX;
  logic [4:0]  Rn_ID;
  logic [4:0]  Rm_ID;
  logic        useRm_ID;
  logic        branchTaken_EX;
  logic        memBusy_MEM;

  logic        PCWrite;
  logic        IFID_Write;
  logic        IFID_Flush;
  logic        IDEX_Bubble;
  logic        pipeHold;
  logic        fwdEN;
  logic        memTimeout;
  logic [15:0] stallCycles;
  logic [15:0] flushCount;

  modport slave (
    input  MemRead_EX, targetReg_EX, Rn_ID, Rm_ID, useRm_ID, branchTaken_EX, memBusy_MEM,
    output PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, pipeHold, fwdEN, memTimeout,
           stallCycles, flushCount
  );

  modport master (
    output MemRead_EX, targetReg_EX, Rn_ID, Rm_ID, useRm_ID, branchTaken_EX, memBusy_MEM,
    input  PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, pipeHold, fwdEN, memTimeout,
           stallCycles, flushCount
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, taken-branch flushes and memory wait holds.
// Controls are Mealy on the current inputs; state, counters and the timeout flag register.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LDUSE_STALLS = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz,
  output hazard_state_t dbg_state
);

  localparam logic [1:0] LDUSE_REM = 2'(LDUSE_STALLS - 1);
  localparam logic [1:0] FLUSH_REM = 2'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_MAX  = 8'(MEM_TIMEOUT);
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  hazard_state_t    state;
  hazard_state_t    state_n;
  logic [1:0]       rem;
  logic [1:0]       rem_n;
  logic [7:0]       wait_cnt;
  logic             mem_timeout;
  logic             hold;
  logic             ldu_hit;
  logic             flush_inc;
  ctrl_t            ctrl;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  assign ldu_hit = load_use_hit(hz.MemRead_EX, hz.targetReg_EX, hz.Rn_ID, hz.Rm_ID,
                                hz.useRm_ID);
  // Once a busy episode has lasted MEM_TIMEOUT cycles the freeze lets go.
  assign hold    = hz.memBusy_MEM && (wait_cnt < WAIT_MAX);

  always_comb begin
    ctrl      = CTRL_RUN;
    state_n   = state;
    rem_n     = rem;
    flush_inc = 1'b0;
    if (hold) begin
      ctrl = CTRL_HOLD;
    end else if (hz.branchTaken_EX) begin
      ctrl      = CTRL_FLUSH;
      flush_inc = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_n = FLUSH;
        rem_n   = FLUSH_REM;
      end else begin
        state_n = RUN;
        rem_n   = 2'd0;
      end
    end else begin
      case (state)
        FLUSH: begin
          ctrl = CTRL_FLUSH;
          if (rem == 2'd1) begin
            state_n = RUN;
            rem_n   = 2'd0;
          end else begin
            rem_n = rem - 2'd1;
          end
        end
        LDUSE: begin
          ctrl = CTRL_STALL;
          if (rem == 2'd1) begin
            state_n = RUN;
            rem_n   = 2'd0;
          end else begin
            rem_n = rem - 2'd1;
          end
        end
        default: begin
          if (ldu_hit) begin
            ctrl = CTRL_STALL;
            if (LDUSE_STALLS > 1) begin
              state_n = LDUSE;
              rem_n   = LDUSE_REM;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      rem         <= 2'd0;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      if (!hz.memBusy_MEM) begin
        wait_cnt <= 8'd0;
      end else if (wait_cnt < WAIT_MAX) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (hold && (wait_cnt == WAIT_LAST)) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!ctrl.pc_write),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_count)
  );

  // Reset overrides the controls asynchronously so the front end loads NOPs.
  always_comb begin
    if (!rst_n) begin
      hz.PCWrite     = 1'b0;
      hz.IFID_Write  = 1'b0;
      hz.IFID_Flush  = 1'b1;
      hz.IDEX_Bubble = 1'b1;
      hz.pipeHold    = 1'b0;
    end else begin
      hz.PCWrite     = ctrl.pc_write;
      hz.IFID_Write  = ctrl.ifid_write;
      hz.IFID_Flush  = ctrl.ifid_flush;
      hz.IDEX_Bubble = ctrl.idex_bubble;
      hz.pipeHold    = ctrl.pipe_hold;
    end
  end

  assign hz.fwdEN       = rst_n;
  assign hz.memTimeout  = mem_timeout;
  assign hz.stallCycles = stall_count;
  assign hz.flushCount  = flush_count;
  assign dbg_state      = state;

endmodule
